// File: rtl/jk_seq_pkg.sv
// Shared opcodes and FSM state type for the JK bank sequencer.
// Imported by jk_bank_seq and its count-term helper.
package jk_seq_pkg;

    localparam logic [2:0] OP_HOLD   = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_TOGGLE = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_CNT_UP = 3'd5;
    localparam logic [2:0] OP_CNT_DN = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_COUNT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/jk_cnt_term.sv
// Per-bit toggle enables for a JK ripple count: bit i toggles when all
// lower bits are 1 (up) or all 0 (down). Ports: up, q in; t out.
module jk_cnt_term #(
    parameter int W = 4
) (
    input  logic         up,
    input  logic [W-1:0] q,
    output logic [W-1:0] t
);

    logic [W-1:0] p;
    logic [W-1:0] lm;

    // Bits above the prefix are forced to 1 before the AND-reduce.
    always_comb begin
        p  = up ? q : ~q;
        lm = '0;
        t  = '0;
        for (int i = 0; i < W; i++) begin
            lm   = (W'(1) << i) - W'(1);
            t[i] = &(p | ~lm);
        end
    end

endmodule

// File: rtl/jk_bank_seq.sv
// Command sequencer driving j/k of an external W-bit JK flip-flop bank.
// Ports: cmd_* handshake in, abort, q in; j/k, busy, done, err out.
module jk_bank_seq
    import jk_seq_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [W-1:0]     cmd_mask,
    input  logic [W-1:0]     cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             abort,
    input  logic [W-1:0]     q,
    output logic [W-1:0]     j,
    output logic [W-1:0]     k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state;
    logic [2:0]       op_q;
    logic [W-1:0]     mask_q;
    logic [W-1:0]     data_q;
    logic [CNT_W-1:0] rem_q;
    logic [W-1:0]     tgl;
    logic             is_cnt;

    assign is_cnt = (cmd_op == OP_CNT_UP) || (cmd_op == OP_CNT_DN);

    jk_cnt_term #(.W(W)) u_term (
        .up (op_q == OP_CNT_UP),
        .q  (q),
        .t  (tgl)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            mask_q <= '0;
            data_q <= '0;
            rem_q  <= '0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        mask_q <= cmd_mask;
                        data_q <= cmd_data;
                        rem_q  <= cmd_cnt;
                        if (cmd_op == OP_RSVD)
                            err <= 1'b1;
                        if (!is_cnt)
                            state <= ST_EXEC;
                        else if (cmd_cnt == '0)
                            state <= ST_DONE;
                        else
                            state <= ST_COUNT;
                    end
                end
                ST_EXEC: state <= ST_DONE;
                ST_COUNT: begin
                    if (abort || rem_q == CNT_W'(1))
                        state <= ST_DONE;
                    else
                        rem_q <= rem_q - CNT_W'(1);
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // j/k decode straight from state so a reset clears them at once.
    always_comb begin
        j = '0;
        k = '0;
        if (state == ST_EXEC) begin
            case (op_q)
                OP_CLEAR:  k = mask_q;
                OP_SET:    j = mask_q;
                OP_TOGGLE: begin
                    j = mask_q;
                    k = mask_q;
                end
                OP_LOAD: begin
                    j = mask_q & data_q;
                    k = mask_q & ~data_q;
                end
                default: ;
            endcase
        end else if (state == ST_COUNT && !abort) begin
            j = tgl;
            k = tgl;
        end
    end

endmodule

// File: doc/jk_bank_seq.md
Name: jk_bank_seq

Overview:
- Command-driven sequencer for a W-bit bank of JK flip-flops (one jk_ff per bit, outside this block).
- Accepts one command at a time over a valid/ready handshake.
- Drives the bank's j/k vectors to hold, clear, set, toggle, load or count, reading the bank's q back for count sequencing.
- Sits between a host/control FSM and the JK register bank.

Parameters:
- W, 4, width of the JK bank.
- CNT_W, 8, width of the count-length field.

Ports:
- clk  input  1  rising-edge clock, shared with the JK bank.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  opcode, see Behaviour.
- cmd_mask  input  W  per-bit enable for CLEAR/SET/TOGGLE/LOAD.
- cmd_data  input  W  load value for LOAD.
- cmd_cnt  input  CNT_W  number of count steps for CNT_UP/CNT_DN.
- abort  input  1  stop an in-progress count.
- q  input  W  current JK bank state.
- j  output  W  J inputs to the bank.
- k  output  W  K inputs to the bank.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky flag, reserved opcode seen.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; j=k=0; busy=0; done=0; err=0.
  - Internal op/mask/data/count registers cleared.
- Opcodes:
  - 0 HOLD: j=k=0.
  - 1 CLEAR: j=0, k=mask.
  - 2 SET: j=mask, k=0.
  - 3 TOGGLE: j=k=mask.
  - 4 LOAD: j=mask&data, k=mask&~data.
  - 5 CNT_UP, 6 CNT_DN.
  - 7 reserved: executed as HOLD; sets err, which stays 1 until reset.
- cmd_ready=1 only in IDLE. Handshake fires on a rising edge with cmd_valid&cmd_ready; op, mask, data and cnt are registered at that edge.
- States:
  - IDLE: j=k=0; on accept go to EXEC for ops 0-4 and 7, to COUNT for ops 5-6 with cnt>0, to DONE for ops 5-6 with cnt=0.
  - EXEC: drive the op's j/k for exactly one cycle, so the bank updates on the edge leaving EXEC; next state DONE.
  - COUNT: bit i gets j[i]=k[i]=&q[i-1:0] (CNT_UP) or &~q[i-1:0] (CNT_DN), with bit 0 always 1. j/k are combinational from q and the registered op. Remaining count decrements each cycle; leaving COUNT when remaining reaches 1 or abort=1.
  - DONE: j=k=0; done=1 for one cycle; next state IDLE.
- busy=1 in EXEC, COUNT and DONE.
- Latency:
  - Ops 0-4 and 7: accept edge → EXEC → DONE; done asserts 2 cycles after accept.
  - Count ops: done asserts cnt+1 cycles after accept.
- Mask is ignored for counts; all W bits count.
- Wrap-around is natural: all-ones +1 → 0, 0 −1 → all-ones.
- Abort:
  - Sampled in COUNT only. With abort=1, j/k are forced to 0 in that cycle (no further step) and the next state is DONE.
  - Ignored in IDLE, EXEC and DONE.
- cmd_valid is ignored while busy; no queuing.
- Reset asserted mid-operation: immediate return to IDLE, j=k=0, no done pulse.
- j and k never both 1 on a bit except under TOGGLE or COUNT.

Decomposition:
- Shared package jk_seq_pkg holds:
  - opcode constants OP_HOLD..OP_RSVD (3-bit);
  - state typedef for IDLE/EXEC/COUNT/DONE (2-bit).
- One sub-module is natural: jk_cnt_term, a combinational W-bit prefix-AND producing per-bit toggle enables for up/down count.
- No other hierarchy.

Test Plan:
Bench closes the loop through a 4-bit bank of jk_ff cells (W=4, CNT_W=8).
- Reset then LOAD data=1010, mask=1111 → one cycle j=1010, k=0101; q=1010; done pulses 2 cycles after accept; err=0.
- From q=1010: TOGGLE mask=0011 → q=1001. CLEAR mask=1000 → q=0001. SET mask=0110 → q=0111. HOLD → q unchanged at 0111.
- From q=1110: CNT_UP cnt=3 → q goes 1111, 0000, 0001 on successive edges; done 4 cycles after accept. Then CNT_DN cnt=2 from 0001 → q=0000, 1111.
- CNT_UP with cnt=0 → no j/k activity, q unchanged, done 1 cycle after accept. Opcode 7 → q unchanged, err=1 and stays 1 across later commands.
- CNT_UP cnt=10 from 0000 with abort=1 in the 4th COUNT cycle → q stops at 0011; done on the next cycle; cmd_ready returns 1. Separately, rst=0 mid-count → j=k=0 immediately, busy=0, no done pulse, cmd_ready=1.
